data_read_port: RTL and testbench
=================================

# data_read_port

Dual read port for the 8-entry data register file, the read-side counterpart of the write-address decoder. It takes two independent 3-bit read addresses, selects the addressed register from the flattened register-file bus, and returns the data one clock later with a valid strobe. It also provides write-first bypass from the same-cycle write, and a sticky error flag for an illegal write-enable vector. It sits between the data register bank and the ALU operand latches.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one register
- ADDR_WIDTH, 3, read address width; NUM_REGS = 2**ADDR_WIDTH (8)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Reg_bus_  in  NUM_REGS*DATA_WIDTH  current register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- Data_read_address_a_  in  ADDR_WIDTH  port A register index
- Enable_read_a_  in  1  port A read request
- Data_read_address_b_  in  ADDR_WIDTH  port B register index
- Enable_read_b_  in  1  port B read request
- Write_enabler_  in  NUM_REGS  one-hot write enable from the write decoder; all-zero means no write
- Write_data_  in  DATA_WIDTH  data being written this cycle
- Read_data_a_  out  DATA_WIDTH  port A registered read data
- Read_valid_a_  out  1  port A data valid, one-cycle pulse per request
- Read_data_b_  out  DATA_WIDTH  port B registered read data
- Read_valid_b_  out  1  port B data valid
- Write_error_  out  1  sticky: Write_enabler_ had more than one bit set

## Operation
- Ports A and B are identical and independent. Both may read the same address in the same cycle.
- On an edge with Enable_read_x_=1:
  - Read_data_x_ <= bypass ? Write_data_ : Reg_bus_ slice[Data_read_address_x_]
  - Read_valid_x_ <= 1
- Bypass condition: Write_enabler_[Data_read_address_x_]=1 in the same cycle as the request (write-first semantics). Bypass applies only when Write_enabler_ is exactly one-hot.
- On an edge with Enable_read_x_=0: Read_valid_x_ <= 0; Read_data_x_ holds its last value.
- Write_error_ is set on any edge where popcount(Write_enabler_) > 1. It stays set until reset. Reads in that cycle ignore the bypass and return the Reg_bus_ value.
- No backpressure: a request is accepted on every enabled edge, and back-to-back requests give one valid per cycle.
- Address values are always in range (full decode); there is no default or illegal address.

## Timing
- Reset values: Read_data_a_ = Read_data_b_ = 0, Read_valid_a_ = Read_valid_b_ = 0, Write_error_ = 0.
- Read latency: request at edge N, data and valid visible after edge N; no combinational input-to-output path.
- Reset asserted mid-operation: outputs clear asynchronously and any in-flight valid is dropped.
- First edge after reset deasserts: normal operation resumes with no extra wait cycle.
- Enable_read_x_ held high: Read_valid_x_ stays high continuously and data follows each cycle's address.
- Write and read to the same address in the same cycle: the read returns Write_data_. The following cycle, Reg_bus_ already carries the new value.

## Structure
- Shared package data_reg_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants
  - a function that extracts register i from the flattened bus
  - an is_onehot0 function
- Sub-module data_read_lane, instantiated twice (A, B). It contains the address mux, bypass select and output registers. Inputs: address, enable, Reg_bus_, Write_enabler_, Write_data_, bypass-allowed. Outputs: data, valid.
- The top level holds the Write_error_ detector and computes bypass-allowed.

## Test plan
- Reset then idle: outputs all zero; after a read with Enable_read_a_=0, Read_valid_a_ stays 0.
- Reg_bus_ with reg i = 8'h10+i; A reads addr 3 and B reads addr 7 on the same edge -> next cycle Read_data_a_=8'h13, Read_data_b_=8'h17, both valids = 1 for exactly one cycle.
- A reads addr 5 while Write_enabler_=8'b0010_0000 and Write_data_=8'hAA (Reg_bus_ reg5=8'h15) -> Read_data_a_=8'hAA; B reads addr 4 in the same cycle -> 8'h14.
- Write_enabler_=8'b0000_0011 for one cycle while A reads addr 0 -> Write_error_=1 and stays 1; Read_data_a_ = Reg_bus_ reg0, not Write_data_; error clears only on reset.
- Enable_read_b_ high for 4 cycles with addresses 0, 1, 2, 3 -> Read_valid_b_ high for 4 consecutive cycles with matching data; the 5th cycle has enable low -> valid 0, data holds reg3.
- Assert reset between edges while Read_valid_a_=1 -> valid and data drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/data_reg_pkg.sv
// Shared constants, types and helpers for the data register file read side.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package data_reg_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0]          data_t;
  typedef logic [ADDR_WIDTH-1:0]          addr_t;
  typedef logic [NUM_REGS-1:0]            wen_t;
  typedef logic [NUM_REGS*DATA_WIDTH-1:0] bus_t;

  // Register i lives at bits [i*DATA_WIDTH +: DATA_WIDTH] of the flattened bus.
  function automatic data_t get_reg(input bus_t bus, input addr_t idx);
    return bus[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // True when zero or one bit is set.
  function automatic logic is_onehot0(input wen_t v);
    return (v & (v - wen_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/data_read_lane.sv
// One read lane: address mux, write-first bypass select and output registers.
// Latency: 1 cycle from enabled edge to registered data/valid.
// Backpressure: none; a request is accepted on every enabled edge.
// Ports: clk/rst, rd_addr/rd_en (request), reg_bus (register file contents),
//        wr_en/wr_dat (same-cycle write), byp_ok (write vector legal),
//        rd_dat/rd_vld (registered response).
module data_read_lane
  import data_reg_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  addr_t rd_addr,
  input  logic  rd_en,
  input  bus_t  reg_bus,
  input  wen_t  wr_en,
  input  data_t wr_dat,
  input  logic  byp_ok,
  output data_t rd_dat,
  output logic  rd_vld
);

  data_t rd_dat_d, rd_dat_q;
  logic  rd_vld_d, rd_vld_q;

  always_comb begin
    rd_dat_d = rd_dat_q;
    rd_vld_d = rd_en;
    if (rd_en) begin
      // The register bank only takes the write at this edge, so a read of the
      // register being written must forward the incoming data.
      if (byp_ok && wr_en[rd_addr]) begin
        rd_dat_d = wr_dat;
      end else begin
        rd_dat_d = get_reg(reg_bus, rd_addr);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_dat = rd_dat_q;
  assign rd_vld = rd_vld_q;

endmodule

// File: rtl/data_read_port.sv
// Dual read port for the 8-entry data register file with write-first bypass.
// Latency: 1 cycle per port; no combinational input-to-output path.
// Backpressure: none; each port accepts one request per enabled edge.
// Ports: clk/reset, Reg_bus_ (flattened registers), per-port address/enable,
//        Write_enabler_/Write_data_ (same-cycle write), per-port data/valid,
//        Write_error_ (sticky multi-hot write enable).
module data_read_port #(
  parameter int DATA_WIDTH = data_reg_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = data_reg_pkg::ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] Reg_bus_,
  input  logic [ADDR_WIDTH-1:0]              Data_read_address_a_,
  input  logic                               Enable_read_a_,
  input  logic [ADDR_WIDTH-1:0]              Data_read_address_b_,
  input  logic                               Enable_read_b_,
  input  logic [(2**ADDR_WIDTH)-1:0]         Write_enabler_,
  input  logic [DATA_WIDTH-1:0]              Write_data_,
  output logic [DATA_WIDTH-1:0]              Read_data_a_,
  output logic                               Read_valid_a_,
  output logic [DATA_WIDTH-1:0]              Read_data_b_,
  output logic                               Read_valid_b_,
  output logic                               Write_error_
);

  import data_reg_pkg::*;

  logic byp_ok;
  logic wr_err_d, wr_err_q;

  // A multi-hot write vector is a decoder fault: the bank contents are
  // suspect, so forwarding is suppressed and reads fall back to the bus.
  assign byp_ok = is_onehot0(Write_enabler_);

  always_comb begin
    wr_err_d = wr_err_q | ~byp_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign Write_error_ = wr_err_q;

  data_read_lane u_lane_a (
    .clk     (clk),
    .rst     (reset),
    .rd_addr (Data_read_address_a_),
    .rd_en   (Enable_read_a_),
    .reg_bus (Reg_bus_),
    .wr_en   (Write_enabler_),
    .wr_dat  (Write_data_),
    .byp_ok  (byp_ok),
    .rd_dat  (Read_data_a_),
    .rd_vld  (Read_valid_a_)
  );

  data_read_lane u_lane_b (
    .clk     (clk),
    .rst     (reset),
    .rd_addr (Data_read_address_b_),
    .rd_en   (Enable_read_b_),
    .reg_bus (Reg_bus_),
    .wr_en   (Write_enabler_),
    .wr_dat  (Write_data_),
    .byp_ok  (byp_ok),
    .rd_dat  (Read_data_b_),
    .rd_vld  (Read_valid_b_)
  );

endmodule

// File: tb/tb_data_read_port.sv
// Scoreboard bench for data_read_port: the driver records each accepted read's
// expected data at the sampling edge, the monitor compares at the falling edge.
module tb_data_read_port;

  logic        clk;
  logic        reset;
  logic [63:0] Reg_bus_;
  logic [2:0]  Data_read_address_a_;
  logic        Enable_read_a_;
  logic [2:0]  Data_read_address_b_;
  logic        Enable_read_b_;
  logic [7:0]  Write_enabler_;
  logic [7:0]  Write_data_;
  logic [7:0]  Read_data_a_;
  logic        Read_valid_a_;
  logic [7:0]  Read_data_b_;
  logic        Read_valid_b_;
  logic        Write_error_;

  data_read_port dut (
    .clk                  (clk),
    .reset                (reset),
    .Reg_bus_             (Reg_bus_),
    .Data_read_address_a_ (Data_read_address_a_),
    .Enable_read_a_       (Enable_read_a_),
    .Data_read_address_b_ (Data_read_address_b_),
    .Enable_read_b_       (Enable_read_b_),
    .Write_enabler_       (Write_enabler_),
    .Write_data_          (Write_data_),
    .Read_data_a_         (Read_data_a_),
    .Read_valid_a_        (Read_valid_a_),
    .Read_data_b_         (Read_data_b_),
    .Read_valid_b_        (Read_valid_b_),
    .Write_error_         (Write_error_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [7:0] regs [8];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] last_a, last_b;
  logic       err_m;
  int         checks, errors;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison set per cycle, after the DUT's edge has settled.
  always @(negedge clk) begin
    logic ev;
    ev = (qa.size() != 0);
    chk("a_valid", {7'd0, Read_valid_a_}, {7'd0, ev});
    if (ev) last_a = qa.pop_front();
    chk("a_data", Read_data_a_, last_a);
    ev = (qb.size() != 0);
    chk("b_valid", {7'd0, Read_valid_b_}, {7'd0, ev});
    if (ev) last_b = qb.pop_front();
    chk("b_data", Read_data_b_, last_b);
    chk("write_error", {7'd0, Write_error_}, {7'd0, err_m});
  end

  // Reference behaviour at a sampling edge, computed from the current inputs.
  task automatic model_edge();
    int pc;
    int idx;
    pc = $countones(Write_enabler_);
    if (pc > 1) err_m = 1'b1;
    if (Enable_read_a_)
      qa.push_back((pc == 1 && Write_enabler_[Data_read_address_a_]) ? Write_data_
                                                                     : regs[Data_read_address_a_]);
    if (Enable_read_b_)
      qb.push_back((pc == 1 && Write_enabler_[Data_read_address_b_]) ? Write_data_
                                                                     : regs[Data_read_address_b_]);
    // The bank commits a legal write at this edge.
    if (pc == 1) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (Write_enabler_[i]) idx = i;
      regs[idx] = Write_data_;
    end
  endtask

  task automatic cycle(input logic ea, input logic [2:0] aa, input logic eb,
                       input logic [2:0] ab, input logic [7:0] we, input logic [7:0] wd);
    for (int i = 0; i < 8; i++) Reg_bus_[i*8 +: 8] = regs[i];
    Enable_read_a_       = ea;
    Data_read_address_a_ = aa;
    Enable_read_b_       = eb;
    Data_read_address_b_ = ab;
    Write_enabler_       = we;
    Write_data_          = wd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] we_r;
    checks = 0;
    errors = 0;
    last_a = 8'h00;
    last_b = 8'h00;
    err_m  = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    reset = 1'b1;
    Reg_bus_ = '0;
    Enable_read_a_ = 1'b0; Data_read_address_a_ = 3'd0;
    Enable_read_b_ = 1'b0; Data_read_address_b_ = 3'd0;
    Write_enabler_ = 8'h00; Write_data_ = 8'h00;
    #2;
    chk("rst_valid_a", {7'd0, Read_valid_a_}, 8'd0);
    chk("rst_data_a", Read_data_a_, 8'h00);
    chk("rst_valid_b", {7'd0, Read_valid_b_}, 8'd0);
    chk("rst_data_b", Read_data_b_, 8'h00);
    chk("rst_error", {7'd0, Write_error_}, 8'd0);
    #10;
    reset = 1'b0;

    // Idle, including an address with enable low
    cycle(1'b0, 3'd6, 1'b0, 3'd2, 8'h00, 8'h00);
    cycle(1'b0, 3'd1, 1'b0, 3'd0, 8'h00, 8'h00);

    // Both ports, distinct registers, single-cycle valid
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
    cycle(1'b1, 3'd3, 1'b1, 3'd7, 8'h00, 8'h00);
    cycle(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);

    // Bypass on A, plain read on B
    cycle(1'b1, 3'd5, 1'b1, 3'd4, 8'b0010_0000, 8'hAA);
    // Both ports on the same address (now holding AA)
    cycle(1'b1, 3'd5, 1'b1, 3'd5, 8'h00, 8'h00);

    // Multi-hot write: error set, no bypass
    cycle(1'b1, 3'd0, 1'b0, 3'd0, 8'b0000_0011, 8'h55);
    cycle(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);

    // Back-to-back on B, then hold
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b1, 3'(i), 8'h00, 8'h00);
    cycle(1'b0, 3'd0, 1'b0, 3'd6, 8'h00, 8'h00);
    cycle(1'b0, 3'd0, 1'b0, 3'd6, 8'h00, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      if (n % 50 == 0)
        for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 5)      we_r = 8'h00;
      else if (r < 9) we_r = 8'h01 << $urandom_range(0, 7);
      else            we_r = 8'($urandom);
      cycle($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 3) != 0,
            3'($urandom), we_r, 8'($urandom));
    end

    // Asynchronous reset between edges while A is valid
    cycle(1'b1, 3'd2, 1'b1, 3'd6, 8'b1100_0000, 8'h99);
    Enable_read_a_ = 1'b0;
    Enable_read_b_ = 1'b0;
    Write_enabler_ = 8'h00;
    @(negedge clk);
    #1;
    chk("pre_rst_valid_a", {7'd0, Read_valid_a_}, 8'd1);
    reset = 1'b1;
    last_a = 8'h00;
    last_b = 8'h00;
    err_m  = 1'b0;
    #1;
    chk("async_valid_a", {7'd0, Read_valid_a_}, 8'd0);
    chk("async_data_a", Read_data_a_, 8'h00);
    chk("async_valid_b", {7'd0, Read_valid_b_}, 8'd0);
    chk("async_error", {7'd0, Write_error_}, 8'd0);
    #1;
    reset = 1'b0;

    // First edge after reset serves reads immediately
    cycle(1'b1, 3'd2, 1'b1, 3'd1, 8'h00, 8'h00);
    cycle(1'b1, 3'd4, 1'b0, 3'd0, 8'b0001_0000, 8'h3C);
    cycle(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    cycle(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 8'h00);

    @(negedge clk);
    #1;
    chk("drain_a", 8'(qa.size()), 8'd0);
    chk("drain_b", 8'(qb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
